// File: rtl/mips_ctrl.sv
// Multi-cycle MIPS main controller: sequences fetch/decode/execute/memory/write-back
// and decodes datapath strobes and mux selects from state, op, funct and zero.
module mips_ctrl (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] op,
   input  logic [5:0] funct,
   input  logic       zero,
   output logic       pc_wr,
   output logic       ir_wr,
   output logic       gpr_wr,
   output logic       dm_wr,
   output logic [1:0] npc_op,
   output logic [1:0] alu_op,
   output logic       alu_src,
   output logic [1:0] ext_op,
   output logic [1:0] reg_dst,
   output logic [1:0] wb_sel,
   output logic [2:0] state,
   output logic       instr_done
);

   typedef enum logic [2:0] {
      S_FETCH = 3'd0,
      S_DCD   = 3'd1,
      S_EXE   = 3'd2,
      S_MEM   = 3'd3,
      S_WB    = 3'd4
   } state_t;

   state_t cur;

   logic is_r, is_addu, is_subu, is_jr, is_ori, is_lui;
   logic is_lw, is_sw, is_beq, is_j, is_jal, is_nop, is_jump;

   assign is_r    = (op == 6'b000000);
   assign is_addu = is_r && (funct == 6'b100001);
   assign is_subu = is_r && (funct == 6'b100011);
   assign is_jr   = is_r && (funct == 6'b001000);
   assign is_ori  = (op == 6'b001101);
   assign is_lui  = (op == 6'b001111);
   assign is_lw   = (op == 6'b100011);
   assign is_sw   = (op == 6'b101011);
   assign is_beq  = (op == 6'b000100);
   assign is_j    = (op == 6'b000010);
   assign is_jal  = (op == 6'b000011);
   assign is_jump = is_j || is_jal || is_jr;
   assign is_nop  = !(is_addu || is_subu || is_jr || is_ori || is_lui ||
                      is_lw || is_sw || is_beq || is_j || is_jal);

   assign state = cur;

   always_ff @(posedge clk) begin
      if (rst) begin
         cur <= S_FETCH;
      end else begin
         case (cur)
            S_FETCH: cur <= S_DCD;
            S_DCD:   cur <= (is_jump || is_nop) ? S_FETCH : S_EXE;
            S_EXE: begin
               if (is_lw || is_sw)
                  cur <= S_MEM;
               else if (is_addu || is_subu || is_ori || is_lui)
                  cur <= S_WB;
               else
                  cur <= S_FETCH;
            end
            S_MEM:   cur <= is_lw ? S_WB : S_FETCH;
            S_WB:    cur <= S_FETCH;
            default: cur <= S_FETCH;
         endcase
      end
   end

   // Strobes; reset overrides decoding so an aborted instruction writes nothing.
   always_comb begin
      pc_wr      = 1'b0;
      ir_wr      = 1'b0;
      gpr_wr     = 1'b0;
      dm_wr      = 1'b0;
      instr_done = 1'b0;
      if (!rst) begin
         case (cur)
            S_FETCH: begin
               ir_wr = 1'b1;
               pc_wr = 1'b1;
            end
            S_DCD: begin
               pc_wr      = is_jump;
               gpr_wr     = is_jal;
               instr_done = is_jump || is_nop;
            end
            S_EXE: begin
               pc_wr      = is_beq && zero;
               instr_done = is_beq;
            end
            S_MEM: begin
               dm_wr      = is_sw;
               instr_done = is_sw;
            end
            S_WB: begin
               gpr_wr     = 1'b1;
               instr_done = 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Selects follow the instruction; only npc_op depends on state (FETCH -> PC+4).
   always_comb begin
      npc_op  = 2'b00;
      alu_op  = 2'b00;
      alu_src = 1'b0;
      ext_op  = 2'b00;
      reg_dst = 2'b00;
      wb_sel  = 2'b00;
      if (is_addu) begin
         reg_dst = 2'b01;
      end
      if (is_subu) begin
         alu_op  = 2'b01;
         reg_dst = 2'b01;
      end
      if (is_ori) begin
         alu_op  = 2'b10;
         alu_src = 1'b1;
      end
      if (is_lui) begin
         alu_op  = 2'b10;
         alu_src = 1'b1;
         ext_op  = 2'b10;
      end
      if (is_lw || is_sw) begin
         alu_src = 1'b1;
         ext_op  = 2'b01;
      end
      if (is_lw) begin
         wb_sel = 2'b01;
      end
      if (is_beq) begin
         npc_op = 2'b01;
         alu_op = 2'b01;
         ext_op = 2'b01;
      end
      if (is_j || is_jal) begin
         npc_op = 2'b10;
      end
      if (is_jal) begin
         reg_dst = 2'b10;
         wb_sel  = 2'b10;
      end
      if (is_jr) begin
         npc_op = 2'b11;
      end
      if (cur == S_FETCH) begin
         npc_op = 2'b00;
      end
   end

endmodule

// File: tb/tb_mips_ctrl.sv
// Bench for mips_ctrl: per-instruction phase model drives an expected queue checked
// every cycle, plus literal pins on key cycles; directed then randomized instructions.
module tb_mips_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [5:0] op, funct;
   logic       zero;
   logic       pc_wr, ir_wr, gpr_wr, dm_wr, alu_src, instr_done;
   logic [1:0] npc_op, alu_op, ext_op, reg_dst, wb_sel;
   logic [2:0] state;

   always #5 clk = ~clk;

   mips_ctrl dut (
      .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero),
      .pc_wr(pc_wr), .ir_wr(ir_wr), .gpr_wr(gpr_wr), .dm_wr(dm_wr),
      .npc_op(npc_op), .alu_op(alu_op), .alu_src(alu_src), .ext_op(ext_op),
      .reg_dst(reg_dst), .wb_sel(wb_sel), .state(state), .instr_done(instr_done)
   );

   // {pc,ir,gpr,dm, npc,alu,src,ext,reg_dst,wb, state, done}
   logic [18:0] act;
   assign act = {pc_wr, ir_wr, gpr_wr, dm_wr, npc_op, alu_op, alu_src, ext_op,
                 reg_dst, wb_sel, state, instr_done};

   localparam logic [18:0] FULL_M  = '1;
   localparam logic [18:0] RST_M   = 19'b1111_00_00_0_00_00_00_111_1;
   localparam logic [18:0] FETCH_M = 19'b1111_11_00_0_00_00_00_111_1;

   localparam int K_ADDU = 0, K_SUBU = 1, K_JR = 2, K_ORI = 3, K_LUI = 4, K_LW = 5;
   localparam int K_SW = 6, K_BEQ = 7, K_J = 8, K_JAL = 9, K_NOP = 10;

   int n_cmp = 0;
   int n_err = 0;
   logic [18:0] exp_q[$];
   logic [18:0] msk_q[$];

   function automatic int decode(input logic [5:0] o, input logic [5:0] f);
      case (o)
         6'b000000: begin
            if (f == 6'b100001) return K_ADDU;
            if (f == 6'b100011) return K_SUBU;
            if (f == 6'b001000) return K_JR;
            return K_NOP;
         end
         6'b001101: return K_ORI;
         6'b001111: return K_LUI;
         6'b100011: return K_LW;
         6'b101011: return K_SW;
         6'b000100: return K_BEQ;
         6'b000010: return K_J;
         6'b000011: return K_JAL;
         default:   return K_NOP;
      endcase
   endfunction

   // {npc_op, alu_op, alu_src, ext_op, reg_dst, wb_sel}
   function automatic logic [10:0] sel_of(input int k);
      case (k)
         K_ADDU:  return 11'b00_00_0_00_01_00;
         K_SUBU:  return 11'b00_01_0_00_01_00;
         K_JR:    return 11'b11_00_0_00_00_00;
         K_ORI:   return 11'b00_10_1_00_00_00;
         K_LUI:   return 11'b00_10_1_10_00_00;
         K_LW:    return 11'b00_00_1_01_00_01;
         K_SW:    return 11'b00_00_1_01_00_00;
         K_BEQ:   return 11'b01_01_0_01_00_00;
         K_J:     return 11'b10_00_0_00_00_00;
         K_JAL:   return 11'b10_00_0_00_10_10;
         default: return 11'b0;
      endcase
   endfunction

   function automatic int len_of(input int k);
      case (k)
         K_J, K_JAL, K_JR, K_NOP: return 2;
         K_BEQ:                   return 3;
         K_LW:                    return 5;
         default:                 return 4;
      endcase
   endfunction

   // State visited in cycle c of an instruction of kind k.
   function automatic logic [2:0] st_of(input int k, input int c);
      if (c < 3) return 3'(c);
      if (k == K_SW || (k == K_LW && c == 3)) return 3'd3;
      return 3'd4;
   endfunction

   task automatic check(input string nm, input logic [18:0] a, input logic [18:0] e,
                        input logic [18:0] m);
      n_cmp++;
      if (((a ^ e) & m) != 19'b0) begin
         n_err++;
         $display("FAIL %s: got %05h want %05h (mask %05h) at %0t", nm, a, e, m, $time);
      end
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         logic [18:0] e, m;
         e = exp_q.pop_front();
         m = msk_q.pop_front();
         check("cycle", act, e, m);
      end
   end

   // One instruction; FETCH sees a random stale op. abort_k asserts rst in that cycle.
   task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input int zf,
                            input int pin_k, input logic [18:0] pin_v,
                            input logic [18:0] pin_m, input int abort_k, input string nm);
      int ik, n;
      ik = decode(o, f);
      n  = len_of(ik);
      for (int c = 0; c < n; c++) begin
         logic [5:0]  go, gf;
         logic        z, pc, ir, gw, dw;
         logic [10:0] s;
         logic [18:0] e;
         int          ck;
         @(posedge clk);
         #1;
         rst = (c == abort_k);
         if (c == 0) begin
            go = 6'($urandom);
            gf = 6'($urandom);
            op = go;
            funct = gf;
            ck = decode(go, gf);
         end else begin
            op = o;
            funct = f;
            ck = ik;
         end
         z = (c == 2 && zf >= 0) ? zf[0] : 1'($urandom);
         zero = z;
         s = sel_of(ck);
         if (c == 0) s[10:9] = 2'b00;
         pc = (c == 0) || (c == 1 && (ik == K_J || ik == K_JAL || ik == K_JR)) ||
              (c == 2 && ik == K_BEQ && z);
         ir = (c == 0);
         gw = (c == 1 && ik == K_JAL) ||
              (c == n - 1 && (ik == K_ADDU || ik == K_SUBU || ik == K_ORI ||
                              ik == K_LUI || ik == K_LW));
         dw = (c == n - 1 && ik == K_SW);
         e = {pc, ir, gw, dw, s, st_of(ik, c), 1'(c == n - 1)};
         if (c == abort_k) begin
            e[18:15] = 4'b0;
            e[0] = 1'b0;
            exp_q.push_back(e);
            msk_q.push_back(RST_M);
         end else begin
            exp_q.push_back(e);
            msk_q.push_back(FULL_M);
         end
         if (c == pin_k) begin
            @(negedge clk);
            check(nm, act, pin_v, pin_m);
         end
         if (c == abort_k) return;
      end
   endtask

   task automatic pick(output logic [5:0] o, output logic [5:0] f);
      f = 6'($urandom);
      case ($urandom_range(0, 11))
         0:  begin o = 6'b000000; f = 6'b100001; end
         1:  begin o = 6'b000000; f = 6'b100011; end
         2:  begin o = 6'b000000; f = 6'b001000; end
         3:  o = 6'b001101;
         4:  o = 6'b001111;
         5:  o = 6'b100011;
         6:  o = 6'b101011;
         7:  o = 6'b000100;
         8:  o = 6'b000010;
         9:  o = 6'b000011;
         10: begin
            o = 6'b000000;
            while (f == 6'b100001 || f == 6'b100011 || f == 6'b001000) f = 6'($urandom);
         end
         default: begin
            o = 6'($urandom);
            while (decode(o, 6'b0) != K_NOP) o = 6'($urandom);
         end
      endcase
   endtask

   initial begin
      logic [5:0] ro, rf;
      int ab;
      rst = 1'b1;
      op = 6'b100011;
      funct = 6'b0;
      zero = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         exp_q.push_back(19'b0);
         msk_q.push_back(RST_M);
      end

      run_instr(6'b000000, 6'b100001, -1, 0, 19'b1100_00_00_0_00_00_00_000_0, FETCH_M, -1, "first_fetch");
      run_instr(6'b000000, 6'b100001, -1, 3, 19'b0010_00_00_0_00_01_00_100_1, FULL_M, -1, "addu_wb");
      run_instr(6'b100011, 6'b010101, -1, 4, 19'b0010_00_00_1_01_00_01_100_1, FULL_M, -1, "lw_wb");
      run_instr(6'b101011, 6'b000000, -1, 3, 19'b0001_00_00_1_01_00_00_011_1, FULL_M, -1, "sw_mem");
      run_instr(6'b000100, 6'b000000, 1, 2, 19'b1000_01_01_0_01_00_00_010_1, FULL_M, -1, "beq_taken");
      run_instr(6'b000100, 6'b000000, 0, 2, 19'b0000_01_01_0_01_00_00_010_1, FULL_M, -1, "beq_not_taken");
      run_instr(6'b000011, 6'b000000, -1, 1, 19'b1010_10_00_0_00_10_10_001_1, FULL_M, -1, "jal_dcd");
      run_instr(6'b000000, 6'b001000, -1, 1, 19'b1000_11_00_0_00_00_00_001_1, FULL_M, -1, "jr_dcd");
      run_instr(6'b111111, 6'b000000, -1, 1, 19'b0000_00_00_0_00_00_00_001_1, FULL_M, -1, "illegal_op");
      run_instr(6'b101011, 6'b000000, -1, 3, 19'b0000_00_00_1_01_00_00_011_0, RST_M, 3, "sw_reset_mem");
      run_instr(6'b000000, 6'b100011, -1, 0, 19'b1100_00_00_0_00_00_00_000_0, FETCH_M, -1, "fetch_after_abort");

      for (int i = 0; i < 200; i++) begin
         pick(ro, rf);
         ab = ($urandom_range(0, 19) == 0) ? $urandom_range(0, len_of(decode(ro, rf)) - 1) : -1;
         run_instr(ro, rf, -1, -1, 19'b0, 19'b0, ab, "random");
      end

      repeat (2) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/mips_ctrl.md
# mips_ctrl

Multi-cycle main controller for the MIPS CPU. It sequences each instruction through fetch, decode, execute, memory and write-back states, and drives the write strobes and mux selects for the datapath. The datapath consists of the IFU/PC, GPR, ALU, EXT and DM blocks. It is instantiated inside `mips`, and its standalone bench joins the unit-test start/finish chain directly after `gpr_test`.

## Interface
Parameters: none. Opcode and funct encodings are fixed MIPS-I values.

- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- op  in  6  IR[31:26], from the instruction register
- funct  in  6  IR[5:0]
- zero  in  1  ALU zero flag
- pc_wr  out  1  PC write strobe
- ir_wr  out  1  IR write strobe
- gpr_wr  out  1  register file write strobe
- dm_wr  out  1  data memory write strobe
- npc_op  out  2  next-PC select: 00 PC+4, 01 branch, 10 j/jal target, 11 rs (jr)
- alu_op  out  2  ALU function: 00 add, 01 sub, 10 or
- alu_src  out  1  ALU B operand: 0 = rt, 1 = EXT output
- ext_op  out  2  immediate extension: 00 zero-extend, 01 sign-extend, 10 imm<<16
- reg_dst  out  2  write register: 00 rt, 01 rd, 10 $31
- wb_sel  out  2  write-back data: 00 ALU, 01 DM, 10 current PC (already PC+4)
- state  out  3  current state, for debug
- instr_done  out  1  pulses high in the last cycle of each instruction

## Operation
Supported instructions:
- R-type (op=000000) with funct addu=100001, subu=100011, jr=001000
- ori=001101, lui=001111, lw=100011, sw=101011, beq=000100, j=000010, jal=000011

Any other op/funct combination is treated as a nop.

States: FETCH=0, DCD=1, EXE=2, MEM=3, WB=4. Encodings 5-7 are illegal and return to FETCH on the next edge, with all strobes 0.

Output decoding:
- Select outputs (npc_op, alu_op, alu_src, ext_op, reg_dst, wb_sel) are combinational from op/funct in every state.
- Strobes are combinational from state, op, funct and zero.
- All strobes are 0 unless a rule below asserts them.

State behaviour:
- FETCH: ir_wr=1, pc_wr=1, npc_op forced to 00. Next state DCD. op is stale in this state and must not affect the strobes.
- DCD:
  - j: pc_wr=1, npc_op=10.
  - jal: additionally gpr_wr=1, reg_dst=10, wb_sel=10.
  - jr: pc_wr=1, npc_op=11.
  - Each of these, and any nop, asserts instr_done and goes to FETCH. All other instructions go to EXE.
- EXE:
  - beq: alu_op=01, pc_wr=zero, npc_op=01, instr_done=1, next state FETCH.
  - lw/sw: alu_op=00, alu_src=1, ext_op=01, next state MEM.
  - addu/subu/ori/lui: next state WB.
- MEM:
  - sw: dm_wr=1, instr_done=1, next state FETCH.
  - lw: next state WB.
- WB: gpr_wr=1, instr_done=1, next state FETCH.

Select values per instruction:
- addu: alu_op=00, alu_src=0, reg_dst=01, wb_sel=00
- subu: alu_op=01, alu_src=0, reg_dst=01, wb_sel=00
- ori: alu_op=10, alu_src=1, ext_op=00, reg_dst=00, wb_sel=00
- lui: alu_op=10, alu_src=1, ext_op=10, reg_dst=00, wb_sel=00. rs is assumed to be $0, per ISA usage.
- lw: reg_dst=00, wb_sel=01

## Timing
- Reset: on a clock edge with rst=1, state becomes FETCH. While rst is high, every strobe and instr_done is forced to 0, overriding state decoding. The first fetch strobes appear in the first cycle with rst=0.
- Reset mid-instruction aborts the instruction. No partial write occurs in the cycle where rst=1.
- Cycles per instruction:
  - j, jal, jr, nop: 2
  - beq: 3
  - sw: 4
  - addu, subu, ori, lui: 4
  - lw: 5
- At most one of gpr_wr or dm_wr is high in any cycle. pc_wr and gpr_wr are high together only for jal in DCD.
- beq with zero=0: EXE still takes one cycle and instr_done=1, but pc_wr=0.
- zero is sampled only in EXE. Its value in other states has no effect.

## Test plan
- Reset: hold rst=1 for 3 cycles with op=100011 → state=0 and all strobes 0 throughout. First cycle after release: ir_wr=1, pc_wr=1, npc_op=00.
- addu (op=0, funct=100001) → state sequence 0,1,2,4,0. In WB: gpr_wr=1, reg_dst=01, wb_sel=00, instr_done=1.
- lw then sw → lw: states 0,1,2,3,4 with gpr_wr only in WB and wb_sel=01. sw: states 0,1,2,3 with dm_wr=1 only in MEM and ext_op=01.
- beq with zero=1, then zero=0 → with zero=1: EXE has pc_wr=1, npc_op=01. With zero=0: pc_wr=0. Both take 3 cycles.
- jal (op=000011) → DCD: pc_wr=1, gpr_wr=1, npc_op=10, reg_dst=10, wb_sel=10, instr_done=1, then FETCH. jr → DCD: pc_wr=1, npc_op=11.
- Illegal op=111111, plus rst asserted during MEM of a sw → illegal op: 2 cycles, no gpr_wr/dm_wr. Reset during sw MEM: dm_wr=0 in that cycle and state=0 next.
